// File: rtl/distance_accumulator.sv
// rtl/distance_accumulator.sv - pedometer step counter with distance accumulation in tenths of a mile
// IDLE/RUN/HOLD control, saturating counts, sticky saturation flag and a registered milestone pulse.
module distance_accumulator #(
  parameter int STEP_W        = 16,
  parameter int DIST_W        = 16,
  parameter int STEPS_PER_INC = 2048,
  parameter int INC_TENTHS    = 5,
  parameter int MILESTONE     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              step,
  output logic [STEP_W-1:0] step_count,
  output logic [DIST_W-1:0] distance,
  output logic              milestone,
  output logic              saturated,
  output logic              running
);

  localparam int RES_W  = (STEPS_PER_INC > 2) ? $clog2(STEPS_PER_INC) : 1;
  localparam int DW1    = DIST_W + 1;
  localparam int MS_DIV = (MILESTONE > 0) ? MILESTONE : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [STEP_W-1:0] STEP_MAX = '1;
  localparam logic [DIST_W-1:0] DIST_MAX = '1;
  localparam logic [RES_W-1:0]  RES_LAST = RES_W'(STEPS_PER_INC - 1);
  localparam logic [DW1-1:0]    INC_EXT  = DW1'(INC_TENTHS);
  localparam logic [DIST_W-1:0] MS_W     = DIST_W'(MS_DIV);

  logic [1:0]        state_q, state_d;
  logic [RES_W-1:0]  residue_q, residue_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic [DIST_W-1:0] distance_q, distance_d;
  logic              milestone_q, milestone_d;
  logic              saturated_q, saturated_d;
  logic              count_en;
  logic [DW1-1:0]    dist_sum;

  always_comb begin
    state_d      = state_q;
    residue_d    = residue_q;
    step_count_d = step_count_q;
    distance_d   = distance_q;
    milestone_d  = 1'b0;
    saturated_d  = saturated_q;
    count_en     = 1'b0;
    dist_sum     = {1'b0, distance_q} + INC_EXT;

    // start overrides everything, including a coincident step
    if (start) begin
      state_d      = ST_RUN;
      residue_d    = '0;
      step_count_d = '0;
      distance_d   = '0;
      saturated_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (step) begin
            count_en = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (count_en) begin
      if (step_count_q != STEP_MAX) begin
        step_count_d = step_count_q + STEP_W'(1);
      end
      if (residue_q == RES_LAST) begin
        residue_d = '0;
        // once clamped the distance is frozen; the residue keeps wrapping
        if (distance_q != DIST_MAX) begin
          if (dist_sum > {1'b0, DIST_MAX}) begin
            distance_d = DIST_MAX;
          end else begin
            distance_d = dist_sum[DIST_W-1:0];
          end
        end
      end else begin
        residue_d = residue_q + RES_W'(1);
      end
      if ((step_count_d == STEP_MAX) || (distance_d == DIST_MAX)) begin
        saturated_d = 1'b1;
      end
      if ((MILESTONE > 0) && ((distance_d / MS_W) != (distance_q / MS_W))) begin
        milestone_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      residue_q    <= '0;
      step_count_q <= '0;
      distance_q   <= '0;
      milestone_q  <= 1'b0;
      saturated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      residue_q    <= residue_d;
      step_count_q <= step_count_d;
      distance_q   <= distance_d;
      milestone_q  <= milestone_d;
      saturated_q  <= saturated_d;
    end
  end

  assign step_count = step_count_q;
  assign distance   = distance_q;
  assign milestone  = milestone_q;
  assign saturated  = saturated_q;
  assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_distance_accumulator.sv
// tb/tb_distance_accumulator.sv - directed and randomized checks of distance_accumulator
// Three parameterisations share one stimulus stream; the model tracks steps counted since start.
module tb_distance_accumulator;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic step = 1'b0;

  logic [15:0] a_sc, a_dist;
  logic        a_ms, a_sat, a_run;
  logic [15:0] b_sc;
  logic [3:0]  b_dist;
  logic        b_ms, b_sat, b_run;
  logic [2:0]  c_sc;
  logic [15:0] c_dist;
  logic        c_ms, c_sat, c_run;

  int total = 0;
  int passed = 0;
  int failed = 0;

  int n = 0;
  int mstate = 0;
  bit ms_a = 0, ms_b = 0, ms_c = 0;

  always #5 clk = ~clk;

  distance_accumulator #(.STEP_W(16), .DIST_W(16), .STEPS_PER_INC(4), .INC_TENTHS(5), .MILESTONE(10)) u_a (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
    .step_count(a_sc), .distance(a_dist), .milestone(a_ms), .saturated(a_sat), .running(a_run));

  distance_accumulator #(.STEP_W(16), .DIST_W(4), .STEPS_PER_INC(2), .INC_TENTHS(5), .MILESTONE(10)) u_b (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
    .step_count(b_sc), .distance(b_dist), .milestone(b_ms), .saturated(b_sat), .running(b_run));

  distance_accumulator #(.STEP_W(3), .DIST_W(16), .STEPS_PER_INC(4), .INC_TENTHS(5), .MILESTONE(10)) u_c (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
    .step_count(c_sc), .distance(c_dist), .milestone(c_ms), .saturated(c_sat), .running(c_run));

  function automatic int exp_sc(int cnt, int smax);
    return (cnt > smax) ? smax : cnt;
  endfunction

  function automatic int exp_d(int cnt, int spi, int dmax);
    int d;
    d = (cnt / spi) * 5;
    return (d > dmax) ? dmax : d;
  endfunction

  function automatic bit crossed(int cnt, int spi, int dmax);
    return (exp_d(cnt, spi, dmax) / 10) != (exp_d(cnt - 1, spi, dmax) / 10);
  endfunction

  function automatic bit exp_sat(int cnt, int smax, int spi, int dmax);
    return (exp_sc(cnt, smax) == smax) || (exp_d(cnt, spi, dmax) == dmax);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    mstate = 0;
    ms_a = 0;
    ms_b = 0;
    ms_c = 0;
  endtask

  task automatic model_step(input bit st, input bit ps, input bit sp);
    ms_a = 0;
    ms_b = 0;
    ms_c = 0;
    if (st) begin
      mstate = 1;
      n = 0;
    end else if (mstate == 1) begin
      if (ps) begin
        mstate = 2;
      end else if (sp) begin
        n++;
        ms_a = crossed(n, 4, 65535);
        ms_b = crossed(n, 2, 15);
        ms_c = crossed(n, 4, 65535);
      end
    end else if (mstate == 2 && !ps) begin
      mstate = 1;
    end
  endtask

  task automatic check_all();
    check("a.step_count", a_sc, exp_sc(n, 65535));
    check("a.distance", a_dist, exp_d(n, 4, 65535));
    check("a.milestone", a_ms, ms_a);
    check("a.saturated", a_sat, exp_sat(n, 65535, 4, 65535));
    check("a.running", a_run, mstate == 1);
    check("b.distance", b_dist, exp_d(n, 2, 15));
    check("b.milestone", b_ms, ms_b);
    check("b.saturated", b_sat, exp_sat(n, 65535, 2, 15));
    check("c.step_count", c_sc, exp_sc(n, 7));
    check("c.saturated", c_sat, exp_sat(n, 7, 4, 65535));
    check("c.milestone", c_ms, ms_c);
    check("b.running", b_run, c_run);
  endtask

  task automatic cyc(input bit st, input bit ps, input bit sp);
    start = st;
    pause = ps;
    step = sp;
    @(posedge clk);
    model_step(st, ps, sp);
    #1;
    check_all();
  endtask

  initial begin
    bit ps_r;
    model_reset();
    #1;
    check_all();
    #13 reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // increment, distance clamp and step_count limit together
    cyc(1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1);
      if (i == 4) check("t2.dist_after_4", a_dist, 32'd5);
      if (i == 3) check("t5.b_not_sat", b_sat, 32'd0);
    end
    check("t2.dist_after_8", a_dist, 32'd10);
    check("t2.milestone_after_8", a_ms, 32'd1);
    check("t5.b_dist_clamped", b_dist, 32'd15);
    check("t6.c_sc_held", c_sc, 32'd7);
    cyc(0, 0, 1);
    check("t6.c_sat", c_sat, 32'd1);
    cyc(1, 0, 0);
    check("t6.c_cleared", c_sat, 32'd0);

    // pause: steps while pause is high are dropped
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1);
      check("t3.running_hold", a_run, 32'd0);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("t3.step_count", a_sc, 32'd4);
    check("t3.distance", a_dist, 32'd5);

    // start coincident with step
    cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1);
    cyc(1, 0, 1);
    check("t4.step_count", a_sc, 32'd0);
    check("t4.running", a_run, 32'd1);
    cyc(1, 1, 0);
    check("t4.start_pause_run", a_run, 32'd1);
    cyc(0, 1, 0);
    check("t4.then_hold", a_run, 32'd0);

    // asynchronous reset mid-run
    cyc(1, 0, 0);
    for (int i = 0; i < 37; i++) cyc(0, 0, 1);
    check("t1.sc_before", a_sc, 32'd37);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("t1.sc_async", a_sc, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    check("t1.idle_ignores", a_sc, 32'd0);

    // randomized traffic
    ps_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ps_r = ~ps_r;
      cyc($urandom_range(0, 149) == 0, ps_r, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
